mem_access_stage: RTL

- Memory-stage data access unit of the 5-stage RISC-V pipeline.
- Sits between the EX/MEM stage register and the MEM/WB register, and produces ReadDataM for it.
- Converts load/store operations into a req/ack data-memory bus transaction:
  - formats store byte lanes;
  - sign/zero-extends load data;
  - stalls the pipeline until the access completes or times out.

---
 rtl/mem_access_stage.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data access unit of the 5-stage RISC-V pipeline.
// Turns a load/store in MEM into a single req/ack data-memory transaction,
// formats store byte lanes, extends load data and stalls the pipeline until
// the access completes or the ack wait times out.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the bus, go straight to
//               DONE and raise MisalignM for one cycle with ReadDataM = 0.
//   undefined : MisalignM stays 0; halves use addr[1] only and words are
//               forced aligned, so the access proceeds normally.
module mem_access_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemErrM,
  output logic        MisalignM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The wait counter holds 0..ACK_TIMEOUT-1 while BUSY; timeout fires on the
  // last allowed BUSY cycle.
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 32'd1);

  // Byte enables for a store, from funct3 and the byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << off;
      3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across the lanes so any enabled lane carries it.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      3'b000:  d = {4{wd[7:0]}};
      3'b001:  d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Select the addressed byte/half of the read word and sign/zero-extend it.
  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[8*off +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Half with addr[0] set, or word with any low address bit set.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] read_data_q, read_data_d;
  logic        mem_err_q, mem_err_d;
  logic        misalign_q, misalign_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        access_s;
  logic        trap_s;

  assign access_s = MemReadM | MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_s = is_misaligned(Funct3M, ALUResultM[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  // Next-state and datapath capture for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    mem_err_d   = 1'b0;
    misalign_d  = 1'b0;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    case (state_q)
      ST_IDLE: begin
        if (access_s) begin
          we_d   = MemWriteM;
          addr_d = {ALUResultM[31:2], 2'b00};
          be_d   = MemWriteM ? store_be(Funct3M, ALUResultM[1:0]) : 4'b1111;
          wdata_d = MemWriteM ? store_wdata(Funct3M, WriteDataM) : 32'h0000_0000;
          f3_d   = Funct3M;
          off_d  = ALUResultM[1:0];
          cnt_d  = 16'd0;
          if (trap_s) begin
            // Trapped access never touches the bus.
            state_d     = ST_DONE;
            misalign_d  = 1'b1;
            read_data_d = 32'h0000_0000;
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (dmem_ack) begin
          // An ack on the timeout cycle still completes cleanly.
          state_d = ST_DONE;
          if (!we_q) begin
            read_data_d = load_format(f3_q, off_q, dmem_rdata);
          end else begin
            read_data_d = read_data_q;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = ST_DONE;
          read_data_d = 32'h0000_0000;
          mem_err_d   = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and latched bus/result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      read_data_q <= 32'h0000_0000;
      mem_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      mem_err_q   <= mem_err_d;
      misalign_q  <= misalign_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  // Stall must be seen in the same cycle the access appears in MEM.
  assign StallM     = ((state_q == ST_IDLE) & access_s) | (state_q == ST_BUSY);
  // Request comes straight off the state flop, so reset drops it at once.
  assign dmem_req   = (state_q == ST_BUSY);
  assign ReadDataM  = read_data_q;
  assign MemErrM    = mem_err_q;
  assign MisalignM  = misalign_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule
